// File: rtl/binary16_pkg.sv
// Shared binary16 field widths, constants, payload struct and divider state encoding.
package binary16_pkg;

   localparam int unsigned SIGN_W    = 1;
   localparam int unsigned EXP_W     = 5;
   localparam int unsigned MAN_W     = 10;
   localparam int unsigned FP_W      = SIGN_W + EXP_W + MAN_W;
   localparam int unsigned EXP_BIAS  = 15;

   // Internal signed exponent must hold a_exp - b_exp + bias +/- 1, i.e. [-16, 46].
   localparam int unsigned EXP_IW    = 7;
   localparam int unsigned DIV_STEPS = 13;
   localparam int unsigned Q_W       = 13;
   localparam int unsigned REM_W     = 12;
   localparam int unsigned CNT_W     = 4;

   localparam logic [FP_W-1:0] QNAN    = 16'h7E00;
   localparam logic [FP_W-1:0] POS_INF = 16'h7C00;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp16_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DIVIDE    = 2'd1,
      NORMALIZE = 2'd2
   } state_t;

   // Zero exponent: true zero or subnormal, both treated as zero.
   function automatic logic is_zero(input fp16_t x);
      return x.exp == '0;
   endfunction

   function automatic logic is_inf_nan(input fp16_t x);
      return x.exp == '1;
   endfunction

endpackage

// File: rtl/binary16_div_if.sv
// Operand/result handshake bundle between an upstream producer and binary16_div.
interface binary16_div_if;

   logic [binary16_pkg::FP_W-1:0] a;
   logic [binary16_pkg::FP_W-1:0] b;
   logic                          data_valid_in;
   logic [binary16_pkg::FP_W-1:0] result;
   logic                          data_valid_out;
   logic                          busy;

   modport master (
      output a, b, data_valid_in,
      input  result, data_valid_out, busy
   );

   modport slave (
      input  a, b, data_valid_in,
      output result, data_valid_out, busy
   );

endinterface

// File: rtl/binary16_round.sv
// Combinational mantissa rounding plus overflow-to-inf / underflow-to-zero packing.
module binary16_round
   import binary16_pkg::*;
#(
   parameter bit ROUND_NEAREST = 1'b0
) (
   input  logic                     i_sign,
   input  logic signed [EXP_IW-1:0] i_exp,
   input  logic [MAN_W-1:0]         i_man,
   input  logic                     i_guard,
   input  logic                     i_sticky,
   output fp16_t                    o_result_c
);

   localparam logic signed [EXP_IW-1:0] EXP_MAX = EXP_IW'(31);
   localparam logic signed [EXP_IW-1:0] EXP_MIN = EXP_IW'(0);

   logic                     w_inc;
   logic [MAN_W:0]           w_man_sum;
   logic signed [EXP_IW-1:0] w_exp_adj;

   assign w_inc     = ROUND_NEAREST & i_guard & (i_sticky | i_man[0]);
   assign w_man_sum = {1'b0, i_man} + (MAN_W+1)'(w_inc);
   // A mantissa carry-out means 1.111..1 rounded up to 2.0: bump exponent, mantissa wraps to 0.
   assign w_exp_adj = i_exp + $signed(EXP_IW'(w_man_sum[MAN_W]));

   always_comb begin
      o_result_c = '{sign: i_sign, exp: w_exp_adj[EXP_W-1:0], man: w_man_sum[MAN_W-1:0]};
      if (w_exp_adj >= EXP_MAX) begin
         o_result_c = fp16_t'({i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}});
      end else if (w_exp_adj <= EXP_MIN) begin
         o_result_c = fp16_t'({i_sign, {(FP_W-1){1'b0}}});
      end
   end

endmodule

// File: rtl/binary16_div.sv
// Sequential binary16 divider: radix-2 restoring mantissa division, fixed 14-cycle latency.
module binary16_div
   import binary16_pkg::*;
#(
   parameter bit          ROUND_NEAREST = 1'b0,
   parameter int unsigned EXP_BIAS      = binary16_pkg::EXP_BIAS
) (
   input  logic          clk_in,
   input  logic          rst_n,
   binary16_div_if.slave bus
);

   fp16_t                    w_a;
   fp16_t                    w_b;
   logic                     w_sign;
   logic signed [EXP_IW-1:0] w_exp_init;
   logic                     w_special;
   logic [FP_W-1:0]          w_special_val;

   state_t                   r_state;
   state_t                   w_next_state;
   logic                     w_accept;

   logic                     r_sign;
   logic signed [EXP_IW-1:0] r_exp;
   logic [REM_W-1:0]         r_rem;
   logic [MAN_W:0]           r_div;
   logic [Q_W-1:0]           r_q;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_special;
   logic [FP_W-1:0]          r_special_val;
   logic [FP_W-1:0]          r_result;
   logic                     r_dvo;
   logic                     r_busy;

   logic                     w_ge;
   logic [REM_W-1:0]         w_rem_sub;
   logic [REM_W-1:0]         w_rem_next;

   logic [MAN_W-1:0]         w_man;
   logic                     w_g;
   logic                     w_st;
   logic signed [EXP_IW-1:0] w_exp_norm;
   fp16_t                    w_rounded;

   assign w_a        = fp16_t'(bus.a);
   assign w_b        = fp16_t'(bus.b);
   assign w_sign     = w_a.sign ^ w_b.sign;
   assign w_exp_init = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp})
                     + $signed(EXP_IW'(EXP_BIAS));

   // Special-class resolution, evaluated on the operands being accepted.
   always_comb begin
      w_special     = 1'b1;
      w_special_val = QNAN;
      if (is_inf_nan(w_a) || is_inf_nan(w_b) || (is_zero(w_a) && is_zero(w_b))) begin
         w_special_val = QNAN;
      end else if (is_zero(w_b)) begin
         w_special_val = POS_INF | {w_sign, {(FP_W-1){1'b0}}};
      end else if (is_zero(w_a)) begin
         w_special_val = {w_sign, {(FP_W-1){1'b0}}};
      end else begin
         w_special = 1'b0;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.data_valid_in) begin
               w_accept     = 1'b1;
               w_next_state = DIVIDE;
            end
         end
         DIVIDE: begin
            if (r_cnt == CNT_W'(DIV_STEPS - 1)) begin
               w_next_state = NORMALIZE;
            end
         end
         NORMALIZE: w_next_state = IDLE;
         default:   w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // One restoring step: subtract when the divisor fits, then shift the partial remainder.
   assign w_ge       = r_rem >= REM_W'(r_div);
   assign w_rem_sub  = w_ge ? (r_rem - REM_W'(r_div)) : r_rem;
   assign w_rem_next = w_rem_sub << 1;

   // Quotient in [0.5, 2): q[12] set means [1, 2), else shift left one and drop the exponent.
   always_comb begin
      w_man      = r_q[MAN_W+1:2];
      w_g        = r_q[1];
      w_st       = r_q[0] | (r_rem != '0);
      w_exp_norm = r_exp;
      if (!r_q[Q_W-1]) begin
         w_man      = r_q[MAN_W:1];
         w_g        = r_q[0];
         w_st       = (r_rem != '0);
         w_exp_norm = r_exp - EXP_IW'(1);
      end
   end

   binary16_round #(
      .ROUND_NEAREST (ROUND_NEAREST)
   ) u_round (
      .i_sign     (r_sign),
      .i_exp      (w_exp_norm),
      .i_man      (w_man),
      .i_guard    (w_g),
      .i_sticky   (w_st),
      .o_result_c (w_rounded)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_sign        <= 1'b0;
         r_exp         <= '0;
         r_rem         <= '0;
         r_div         <= '0;
         r_q           <= '0;
         r_cnt         <= '0;
         r_special     <= 1'b0;
         r_special_val <= '0;
         r_result      <= '0;
         r_dvo         <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_dvo  <= (r_state == NORMALIZE);
         r_busy <= (w_next_state != IDLE);
         if (w_accept) begin
            r_sign        <= w_sign;
            r_exp         <= w_exp_init;
            r_rem         <= {1'b0, 1'b1, w_a.man};
            r_div         <= {1'b1, w_b.man};
            r_q           <= '0;
            r_cnt         <= '0;
            r_special     <= w_special;
            r_special_val <= w_special_val;
         end else if (r_state == DIVIDE) begin
            r_q   <= {r_q[Q_W-2:0], w_ge};
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == NORMALIZE) begin
            r_result <= r_special ? r_special_val : w_rounded;
         end
      end
   end

   assign bus.result         = r_result;
   assign bus.data_valid_out = r_dvo;
   assign bus.busy           = r_busy;

endmodule

// File: tb/tb_binary16_div.sv
// Scoreboard bench for binary16_div: truncating and round-to-nearest instances side by side.
module tb_binary16_div;

   typedef struct {
      string       name;
      logic [15:0] val;
      int          due;
   } exp_t;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_err  = 0;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   binary16_div_if u_if0 ();
   binary16_div_if u_if1 ();

   binary16_div #(.ROUND_NEAREST(1'b0)) u_dut0 (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (u_if0.slave)
   );

   binary16_div #(.ROUND_NEAREST(1'b1)) u_dut1 (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (u_if1.slave)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic set_in(input logic [15:0] ta, input logic [15:0] tb_v, input logic v);
      u_if0.a = ta; u_if0.b = tb_v; u_if0.data_valid_in = v;
      u_if1.a = ta; u_if1.b = tb_v; u_if1.data_valid_in = v;
   endtask

   // Present one operation as soon as the divider is idle; expected pulse is 14 edges after accept.
   task automatic issue(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] e0, input logic [15:0] e1, input bit push);
      int guard = 0;
      @(negedge clk_in);
      while (u_if0.busy && guard < 40) begin
         @(negedge clk_in);
         guard++;
      end
      if (guard >= 40) chk({name, "_idle_timeout"}, 32'(u_if0.busy), 32'd0);
      set_in(ta, tb_v, 1'b1);
      if (push) begin
         q0.push_back('{name: name, val: e0, due: cyc + 15});
         q1.push_back('{name: name, val: e1, due: cyc + 15});
      end
      @(negedge clk_in);
      set_in(ta, tb_v, 1'b0);
   endtask

   task automatic drain();
      int guard = 0;
      while ((q0.size() != 0 || q1.size() != 0) && guard < 60) begin
         @(negedge clk_in);
         guard++;
      end
      chk("rn0_pending_results", 32'(q0.size()), 32'd0);
      chk("rn1_pending_results", 32'(q1.size()), 32'd0);
   endtask

   always @(negedge clk_in) begin : mon0
      exp_t e;
      if (rst_n && u_if0.data_valid_out) begin
         if (q0.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rn0_unexpected_pulse: got result %h, want no pulse (cycle %0d)",
                     u_if0.result, cyc);
         end else begin
            e = q0.pop_front();
            chk({e.name, "_rn0_result"}, 32'(u_if0.result), 32'(e.val));
            chk({e.name, "_rn0_cycle"}, 32'(cyc), 32'(e.due));
         end
      end
   end

   always @(negedge clk_in) begin : mon1
      exp_t e;
      if (rst_n && u_if1.data_valid_out) begin
         if (q1.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rn1_unexpected_pulse: got result %h, want no pulse (cycle %0d)",
                     u_if1.result, cyc);
         end else begin
            e = q1.pop_front();
            chk({e.name, "_rn1_result"}, 32'(u_if1.result), 32'(e.val));
            chk({e.name, "_rn1_cycle"}, 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] sqrt_out;
      set_in(16'h0000, 16'h0000, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("reset_rn0_result", 32'(u_if0.result), 32'h0);
      chk("reset_rn0_valid",  32'(u_if0.data_valid_out), 32'h0);
      chk("reset_rn0_busy",   32'(u_if0.busy), 32'h0);
      chk("reset_rn1_result", 32'(u_if1.result), 32'h0);
      chk("reset_rn1_valid",  32'(u_if1.data_valid_out), 32'h0);
      chk("reset_rn1_busy",   32'(u_if1.busy), 32'h0);
      rst_n = 1'b1;

      issue("one_div_one", 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 1'b1);
      // Back-to-back: accepted on the pulse edge of the previous op.
      issue("three_div_two", 16'h4200, 16'h4000, 16'h3E00, 16'h3E00, 1'b1);
      repeat (3) @(negedge clk_in);
      chk("busy_mid_op", 32'(u_if0.busy), 32'h1);
      set_in(16'h3C00, 16'h4000, 1'b1);
      @(negedge clk_in);
      set_in(16'h3C00, 16'h4000, 1'b0);

      issue("neg_two_div_three", 16'hC000, 16'h4200, 16'hB955, 16'hB955, 1'b1);
      issue("two_div_zero",      16'h4000, 16'h0000, 16'h7C00, 16'h7C00, 1'b1);
      issue("neg_two_div_zero",  16'hC000, 16'h0000, 16'hFC00, 16'hFC00, 1'b1);
      issue("zero_div_zero",     16'h0000, 16'h0000, 16'h7E00, 16'h7E00, 1'b1);
      issue("inf_div_one",       16'h7C00, 16'h3C00, 16'h7E00, 16'h7E00, 1'b1);
      issue("overflow",          16'h7BFF, 16'h0400, 16'h7C00, 16'h7C00, 1'b1);
      issue("underflow",         16'h0400, 16'h7BFF, 16'h0000, 16'h0000, 1'b1);
      issue("neg_zero_div_two",  16'h8000, 16'h4000, 16'h8000, 16'h8000, 1'b1);

      // Divisor taken from the upstream square root stage: sqrt(4.0) = 2.0.
      sqrt_out = 16'h4000;
      issue("sqrt_chain", 16'h4000, sqrt_out, 16'h3C00, 16'h3C00, 1'b1);
      issue("five_div_three", 16'h4500, 16'h4200, 16'h3EAA, 16'h3EAB, 1'b1);
      drain();

      repeat (3) @(negedge clk_in);
      chk("hold_rn0_result", 32'(u_if0.result), 32'h3EAA);
      chk("hold_rn1_result", 32'(u_if1.result), 32'h3EAB);
      chk("hold_rn0_valid",  32'(u_if0.data_valid_out), 32'h0);

      // Abort an operation mid-divide; it must never produce a pulse.
      issue("aborted", 16'h4000, 16'h4200, 16'h0000, 16'h0000, 1'b0);
      repeat (5) @(negedge clk_in);
      rst_n = 1'b0;
      #1;
      chk("abort_rn0_busy",   32'(u_if0.busy), 32'h0);
      chk("abort_rn0_valid",  32'(u_if0.data_valid_out), 32'h0);
      chk("abort_rn0_result", 32'(u_if0.result), 32'h0);
      chk("abort_rn1_result", 32'(u_if1.result), 32'h0);
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;

      issue("post_reset", 16'h4000, 16'h4000, 16'h3C00, 16'h3C00, 1'b1);
      drain();
      repeat (20) @(negedge clk_in);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
